// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: opcodes, reply bytes and FSM state encoding shared by the
// UART command responder.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_EXEC,
        ST_SEND
    } state_t;

endpackage

// File: rtl/uart_cmd_responder_regfile.sv
// cmd_regfile: 2**ADDR_W x 8-bit register file with one synchronous write
// port, one combinational read port and a live tap of register 0.
module cmd_regfile #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    output logic [7:0]        reg0
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    // Storage: cleared on reset, written on we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign reg0  = mem[0];

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: decodes 'W' addr data / 'R' addr commands popped from a
// UART receive FIFO, accesses a small register file and pushes a one-byte
// reply into the transmit FIFO. Register 0 is exported as ctrl_out.
// Optional feature: define UART_CMD_TIMEOUT_EN to abort a command whose next
// byte does not arrive within TIMEOUT_CYCLES (reply '?').
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic [7:0] ctrl_out
);

    state_t            state;
    logic              armed;
    logic              is_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [7:0]        rd_data;
    logic              fetch;
    logic              reg_we;
    logic              timeout;

    // Pop/push strobes follow the FIFO flags in the same cycle so a byte is
    // never popped from an empty FIFO nor pushed into a full one. armed keeps
    // rd_uart low until the first edge after reset release.
    assign fetch   = (state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign rd_uart = armed && fetch && !rx_empty;
    assign wr_uart = (state == ST_SEND) && !tx_full;
    assign reg_we  = (state == ST_EXEC) && is_wr;

    cmd_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (reg_we),
        .waddr (addr_q),
        .wdata (data_q),
        .raddr (addr_q),
        .rdata (rd_data),
        .reg0  (ctrl_out)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;

    assign waiting = ((state == ST_GET_ADDR) || (state == ST_GET_DATA)) && !rd_uart;
    assign timeout = waiting && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Inter-byte stall counter: runs while a command waits for its next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (waiting && !timeout) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;

    // TIMEOUT_CYCLES has no effect in this build; the empty block only keeps
    // the parameter referenced.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Command FSM: byte capture, execute, reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            armed  <= 1'b0;
            is_wr  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            w_data <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (rd_uart) begin
                        if (r_data == OP_WR) begin
                            is_wr <= 1'b1;
                            state <= ST_GET_ADDR;
                        end else if (r_data == OP_RD) begin
                            is_wr <= 1'b0;
                            state <= ST_GET_ADDR;
                        end else begin
                            w_data <= RSP_ERR;
                            state  <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (rd_uart) begin
                        addr_q <= r_data[ADDR_W-1:0];
                        state  <= is_wr ? ST_GET_DATA : ST_EXEC;
                    end else if (timeout) begin
                        w_data <= RSP_ERR;
                        state  <= ST_SEND;
                    end
                end
                ST_GET_DATA: begin
                    if (rd_uart) begin
                        data_q <= r_data;
                        state  <= ST_EXEC;
                    end else if (timeout) begin
                        w_data <= RSP_ERR;
                        state  <= ST_SEND;
                    end
                end
                ST_EXEC: begin
                    w_data <= is_wr ? RSP_OK : rd_data;
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (wr_uart) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
